// File: rtl/counter_multimode_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Shared types and helpers for the multi-mode counter.
//   cnt_mode_e    : counting mode selector (UP, DOWN, ROTATE, JOHNSON)
//   clamp_to_mod  : limits a value to a maximum (MOD-1) for the binary modes
// -----------------------------------------------------------------------------
package counter_pkg;

   typedef enum logic [1:0] {
      MODE_UP      = 2'd0,
      MODE_DOWN    = 2'd1,
      MODE_ROTATE  = 2'd2,
      MODE_JOHNSON = 2'd3
   } cnt_mode_e;

   // The function uses a fixed 32-bit width so it can serve any counter width.
   // Callers zero-extend their operands and truncate the result.
   function automatic logic [31:0] clamp_to_mod(input logic [31:0] value,
                                               input logic [31:0] max_val);
      logic [31:0] result;
      if (value > max_val) begin
         result = max_val;
      end else begin
         result = value;
      end
      return result;
   endfunction

endpackage

// File: rtl/counter_multimode_if.sv
// -----------------------------------------------------------------------------
// counter_multimode_if
// Control and status bundle of the multi-mode counter.
//   enable, clear, load, load_value, mode : control, driven by the master
//   counter, tc, wrap_cnt                 : status, driven by the counter
// Modports: master (controller side), slave (counter side).
// -----------------------------------------------------------------------------
interface counter_multimode_if #(
   parameter int N      = 8,
   parameter int WRAP_W = 4
) ();
   import counter_pkg::*;

   logic              enable;
   logic              clear;
   logic              load;
   logic [N-1:0]      load_value;
   cnt_mode_e         mode;
   logic [N-1:0]      counter;
   logic              tc;
   logic [WRAP_W-1:0] wrap_cnt;

   modport master (
      output enable, clear, load, load_value, mode,
      input  counter, tc, wrap_cnt
   );

   modport slave (
      input  enable, clear, load, load_value, mode,
      output counter, tc, wrap_cnt
   );

endinterface

// File: rtl/counter_multimode_step.sv
// -----------------------------------------------------------------------------
// counter_step
// Purely combinational next-value logic for one counter step.
//   i_value : current counter value
//   i_mode  : counting mode
//   o_next  : value after one step
//   o_wrap  : this step completes a full sequence (terminal count)
// -----------------------------------------------------------------------------
module counter_step
   import counter_pkg::*;
#(
   parameter int N   = 8,
   parameter int MOD = 2**N
) (
   input  logic [N-1:0] i_value,
   input  cnt_mode_e    i_mode,
   output logic [N-1:0] o_next,
   output logic         o_wrap
);

   // Largest in-range value, held as an N-bit constant so a full-range modulus wraps naturally.
   localparam logic [N-1:0] MOD_MAX = N'(MOD - 1);

   logic [N-1:0] w_johnson;

   // Johnson successor: shift left, feeding back the inverted MSB.
   always_comb begin
      w_johnson = {i_value[N-2:0], ~i_value[N-1]};
   end

   // Next value and wrap flag for each mode.
   always_comb begin
      o_next = i_value;
      o_wrap = 1'b0;
      case (i_mode)
         MODE_UP: begin
            // >= also catches out-of-range values loaded in a shift mode.
            if (i_value >= MOD_MAX) begin
               o_next = {N{1'b0}};
               o_wrap = 1'b1;
            end else begin
               o_next = i_value + N'(1);
               o_wrap = 1'b0;
            end
         end
         MODE_DOWN: begin
            if (i_value == {N{1'b0}}) begin
               o_next = MOD_MAX;
               o_wrap = 1'b1;
            end else if (i_value > MOD_MAX) begin
               // Out-of-range value re-enters the sequence without a wrap.
               o_next = MOD_MAX;
               o_wrap = 1'b0;
            end else begin
               o_next = i_value - N'(1);
               o_wrap = 1'b0;
            end
         end
         MODE_ROTATE: begin
            if (i_value == {N{1'b0}}) begin
               // Self-seed so a cleared register does not rotate zeros forever.
               o_next = N'(1);
               o_wrap = 1'b0;
            end else begin
               o_next = {i_value[N-2:0], i_value[N-1]};
               o_wrap = i_value[N-1];
            end
         end
         MODE_JOHNSON: begin
            o_next = w_johnson;
            o_wrap = (w_johnson == {N{1'b0}});
         end
         default: begin
            o_next = i_value;
            o_wrap = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/counter_multimode.sv
// -----------------------------------------------------------------------------
// counter_multimode
// Parametrised multi-mode counter: binary up/down modulo MOD, one-hot rotate
// and Johnson sequences, synchronous clear/load, terminal-count pulse and a
// saturating wrap counter. Priority per edge: clear > load > enable > hold.
// Ports:
//   clk     : clock, rising edge active
//   reset_n : asynchronous active-low reset
//   bus     : counter_multimode_if.slave
//             (enable, clear, load, load_value, mode -> counter, tc, wrap_cnt)
// -----------------------------------------------------------------------------
module counter_multimode
   import counter_pkg::*;
#(
   parameter int N      = 8,
   parameter int MOD    = 2**N,
   parameter int WRAP_W = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   counter_multimode_if.slave  bus
);

   localparam logic [N-1:0]      MOD_MAX  = N'(MOD - 1);
   localparam logic [WRAP_W-1:0] WRAP_MAX = {WRAP_W{1'b1}};

   logic [N-1:0]      r_counter;
   logic              r_tc;
   logic [WRAP_W-1:0] r_wrap_cnt;

   logic [N-1:0]      w_next;
   logic              w_wrap;
   logic [N-1:0]      w_load_value;

   counter_step #(
      .N   (N),
      .MOD (MOD)
   ) u_step (
      .i_value (r_counter),
      .i_mode  (bus.mode),
      .o_next  (w_next),
      .o_wrap  (w_wrap)
   );

   // Binary modes clamp the loaded value into range; shift modes take it raw.
   always_comb begin
      w_load_value = bus.load_value;
      if ((bus.mode == MODE_UP) || (bus.mode == MODE_DOWN)) begin
         w_load_value = N'(clamp_to_mod(32'(bus.load_value), 32'(MOD_MAX)));
      end else begin
         w_load_value = bus.load_value;
      end
   end

   // Counter, terminal-count pulse and saturating wrap counter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_counter  <= {N{1'b0}};
         r_tc       <= 1'b0;
         r_wrap_cnt <= {WRAP_W{1'b0}};
      end else if (bus.clear) begin
         r_counter  <= {N{1'b0}};
         r_tc       <= 1'b0;
         r_wrap_cnt <= {WRAP_W{1'b0}};
      end else if (bus.load) begin
         r_counter  <= w_load_value;
         r_tc       <= 1'b0;
      end else if (bus.enable) begin
         r_counter  <= w_next;
         r_tc       <= w_wrap;
         if (w_wrap && (r_wrap_cnt != WRAP_MAX)) begin
            r_wrap_cnt <= r_wrap_cnt + WRAP_W'(1);
         end
      end else begin
         // Hold cycles never carry a terminal count.
         r_tc       <= 1'b0;
      end
   end

   assign bus.counter  = r_counter;
   assign bus.tc       = r_tc;
   assign bus.wrap_cnt = r_wrap_cnt;

endmodule

// File: doc/counter_multimode.md
# counter_multimode

Parametrised multi-mode counter, the next generation of the lab2 enable counter. It adds binary up/down counting with a programmable modulus, one-hot rotate and Johnson sequences, synchronous clear and load, a terminal-count pulse and a saturating wrap counter. Shift modes self-seed from zero, so a cleared counter never sticks at 0. The block serves as the general counter in lab designs feeding display, divider and sequencer blocks.

## Interface
- `N`, 8: counter width in bits (N ≥ 2).
- `MOD`, 2**N: modulus for up/down modes (2 ≤ MOD ≤ 2**N).
- `WRAP_W`, 4: width of the wrap counter.
- `clk`  in  1: clock; all state changes on the rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `enable`  in  1: advance one step this cycle.
- `clear`  in  1: synchronous clear of `counter` and `wrap_cnt`.
- `load`  in  1: synchronous load of `load_value`.
- `load_value`  in  N: value to load.
- `mode`  in  2: 0 UP, 1 DOWN, 2 ROTATE, 3 JOHNSON.
- `counter`  out  N: current count, registered.
- `tc`  out  1: registered one-cycle terminal-count pulse.
- `wrap_cnt`  out  WRAP_W: saturating count of `tc` events.

## Operation
- Priority per edge is clear > load > enable > hold.
- **clear**: `counter` is 0, `wrap_cnt` is 0, `tc` is 0.
- **load**:
  - In UP/DOWN, `counter` takes `load_value` clamped to MOD-1.
  - In ROTATE/JOHNSON, `counter` takes `load_value` unclamped.
  - `tc` is 0 and `wrap_cnt` is unchanged.
- **enable**, by mode:
  - UP: if counter ≥ MOD-1, next value is 0 with a wrap; else counter+1.
  - DOWN: if counter = 0, next value is MOD-1 with a wrap. If counter > MOD-1, next value is MOD-1 with no wrap. Else counter-1.
  - ROTATE: if counter = 0, next value is 1 with no wrap. Else rotate left: {counter[N-2:0], counter[N-1]}. A wrap occurs when the old counter[N-1] = 1.
  - JOHNSON: next value is {counter[N-2:0], ~counter[N-1]}. A wrap occurs when the next value is 0.
- A wrap sets `tc` = 1 on the same edge and increments `wrap_cnt`, saturating at all-ones.
- `tc` is 0 on every edge without a wrap, including hold cycles.
- Changing `mode` takes effect on the next step from the current value. No reseeding occurs beyond the ROTATE zero rule.
- All arithmetic is N bits. MOD-1 is computed as an N-bit constant, so MOD = 2**N gives a natural wrap.

## Timing
- Latency is one cycle: inputs sampled at edge k appear on `counter`, `tc` and `wrap_cnt` after edge k.
- `tc` is high exactly in the cycle where `counter` shows the post-wrap value.
- On `reset_n` low, `counter`, `tc` and `wrap_cnt` go to 0 immediately, without waiting for a clock edge. They hold 0 while reset is low.
- Reset deassertion is synchronised by the integrating design. The first step occurs on the first edge with `reset_n` high and `enable` high.
- Reset asserted mid-sequence discards all state. No `tc` is produced for the interrupted step.

## Structure
- Shared package `counter_pkg` holds:
  - typedef enum logic [1:0] `cnt_mode_e` {MODE_UP, MODE_DOWN, MODE_ROTATE, MODE_JOHNSON};
  - the helper function that clamps a value to the modulus.
- Sub-module `counter_step` is purely combinational:
  - inputs: current value and mode;
  - outputs: next value and wrap flag.
- The top module keeps the registers, the priority logic and the `wrap_cnt` saturation.

## Test plan
All scenarios use N=4, MOD=10, WRAP_W=2.
- **Up count**: UP from 0, enable for 10 cycles → `counter` 1..9 then 0. `tc` is high only with the 0. `wrap_cnt` = 1.
- **Down count**: load 2 then DOWN enable → 1, 0, 9 with `tc`. Then load 15 → `counter` 9 (clamped).
- **Rotate from zero**: ROTATE from 0 → 0001, 0010, 0100, 1000, 0001. `tc` is high only on the last step.
- **Johnson**: JOHNSON from 0 → 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000. `tc` is high on 0000.
- **Priority**:
  - clear+load+enable all high → `counter` 0, `wrap_cnt` 0.
  - load+enable → `load_value`, with no step.
- **Saturation and reset**:
  - 5 UP wraps → `wrap_cnt` stays 3.
  - `reset_n` low mid-count at `counter`=7 → `counter`, `tc` and `wrap_cnt` read 0 before the next edge.
